pipe_stage_latch: RTL and testbench
===================================

Name: pipe_stage_latch

Overview:
- Generic, parametrised pipeline-stage register. It replaces the fixed per-stage instruction/operand latches with one block instantiated at every stage boundary (F/D, D/X, X/M, M/W).
- Carries one instruction word, N operand fields and a sideband vector (exception and similar flags) between stages.
- Adds a valid/ready handshake, a registered-ready skid entry, flush-to-bubble and NOP substitution, so hazard logic drives handshake signals instead of raw enables.

Parameters:
- INSN_W, 32, instruction word width.
- NUM_FIELDS, 2, number of operand/data fields carried (O/B, A/B, O/D ...); legal range 1..4.
- FIELD_W, 32, width of each field.
- SIDE_W, 1, sideband width (exception, etc.).
- NOP_INSN, 0, instruction value presented whenever the stage holds no valid entry.
- SKID, 1:
  - 1: two-entry storage (main + skid), in_ready is a pure register output.
  - 0: single entry, in_ready = !valid || out_ready (combinational).

Ports:
- clk  in  1  stage clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising clk.
- in_valid  in  1  upstream offers an entry.
- in_ready  out  1  stage accepts the entry this cycle.
- in_insn  in  INSN_W  incoming instruction.
- in_fields  in  NUM_FIELDS*FIELD_W  operand fields; field k at [k*FIELD_W +: FIELD_W].
- in_side  in  SIDE_W  incoming sideband.
- flush  in  1  kill all held entries (branch mispredict / exception redirect).
- out_valid  out  1  stage presents a valid entry.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_insn  out  INSN_W  held instruction, NOP_INSN when !out_valid.
- out_fields  out  NUM_FIELDS*FIELD_W  held fields, all-zero when !out_valid.
- out_side  out  SIDE_W  held sideband, zero when !out_valid (no stale exception leaks).
- occupancy  out  2  entries held: 0, 1, or 2 (2 only when SKID=1).

Behaviour:
- Handshake events:
  - accept = in_valid && in_ready.
  - consume = out_valid && out_ready.
  - in_valid may be asserted with in_ready low; data is held by upstream until accepted.
- Reset (reset==0 at a rising edge):
  - State EMPTY; out_valid=0, out_insn=NOP_INSN, out_fields=0, out_side=0, occupancy=0, in_ready=1.
  - Overrides accept, consume and flush. Reset mid-transfer drops all entries.
- Latency and throughput:
  - An entry accepted at edge t appears on the outputs after edge t (1 cycle).
  - Sustained throughput is 1 entry/cycle when out_ready is held high.
- State machine (SKID=1):
  - EMPTY:
    - accept → FULL (main loaded).
    - Otherwise stay.
  - FULL:
    - accept && consume → FULL (main reloaded).
    - accept && !consume → SKID (incoming entry to skid); in_ready deasserts next cycle.
    - !accept && consume → EMPTY.
  - SKID:
    - in_ready=0.
    - consume → FULL, skid entry moves to main.
    - Otherwise hold.
  - in_ready = (state != SKID), registered.
  - out_* are always driven from main.
  - Order is strictly FIFO.
- SKID=0:
  - States EMPTY and FULL only.
  - in_ready = (state==EMPTY) || out_ready.
- Flush:
  - Next state EMPTY and all entries invalidated, regardless of accept/consume in the same cycle.
  - An entry offered in the flush cycle is dropped, and the upstream handshake still completes.
  - A consume in the flush cycle still completes downstream (the entry presented that cycle is architecturally older).
  - Payload registers need not be cleared; output gating forces NOP/zero.
- Output gating: when !out_valid, outputs show NOP_INSN/0/0 combinationally from the valid bit.
- No arithmetic beyond the 2-bit occupancy; occupancy = valid_main + valid_skid.

Decomposition:
- Shared package pipe_pkg:
  - State enum {EMPTY, FULL, SKID}.
  - Default NOP constant.
  - Helper localparam PAYLOAD_W = INSN_W + NUM_FIELDS*FIELD_W + SIDE_W.
- Sub-module pipe_entry:
  - One payload register plus valid bit, with load/clear.
  - Instantiated twice (main, skid); skid is generate-guarded by SKID.

Test Plan:
- Reset low 2 cycles with in_valid=1, in_insn=32'hDEADBEEF → out_valid=0, out_insn=0, occupancy=0, in_ready=1. After release, first accept shows DEADBEEF one cycle later.
- Stream insns 1..8, out_ready=1 every cycle → out_insn 1..8 on consecutive cycles, occupancy never exceeds 1.
- SKID=1, stream 1,2,3 with out_ready=0 from cycle 2 → occupancy reaches 2 and in_ready=0. Insn 3 is held by upstream. Raising out_ready drains 1,2,3 in order, with no loss or duplication.
- Occupancy 2 (insns 5,6); assert flush while in_valid=1 with insn 7 → next cycle out_valid=0, out_insn=NOP_INSN, occupancy=0. Insn 7 is not output.
- Accept in_side=1 (exception) then consume with no new input → out_side returns to 0 the cycle after the consume.
- SKID=0, NUM_FIELDS=3, fields {A,B,C} with out_ready toggling 1,0,1 → in_ready tracks out_ready when FULL, and fields appear unchanged at [0+:32], [32+:32], [64+:32].

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the generic pipeline-stage register.
//   pipe_state_e : stage occupancy state (empty / main full / main+skid full)
//   NOP_DEFAULT  : default instruction shown while a stage holds nothing
//   payload_w()  : packed payload width {insn, fields, side}
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

  // Width of one stored entry: instruction, all operand fields, sideband.
  function automatic int payload_w(input int insn_w, input int num_fields,
                                   input int field_w, input int side_w);
    return insn_w + num_fields * field_w + side_w;
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry
// One stage storage slot: a payload register plus its valid bit.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-low reset (clears valid only)
//   i_load   : capture i_d and mark the slot valid
//   i_clear  : invalidate the slot (wins over i_load for the valid bit)
//   i_d      : payload to capture
//   o_q      : stored payload (meaningful only while o_valid)
//   o_valid  : slot holds an entry
// ---------------------------------------------------------------------------
module pipe_entry #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_valid
);

  logic         r_valid;
  logic [W-1:0] r_payload;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
    end
  end

  // NOTE: the payload is deliberately left out of reset; the valid bit gates
  // it everywhere it is observed, so clearing it would only cost reset fanout.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_payload <= i_d;
    end
  end

  assign o_q     = r_payload;
  assign o_valid = r_valid;

endmodule

// File: rtl/pipe_stage_latch.sv
// ---------------------------------------------------------------------------
// pipe_stage_latch
// Generic pipeline-stage register with valid/ready handshake, optional skid
// entry (registered in_ready), flush-to-bubble and NOP substitution.
// Ports:
//   clk, reset           : clock; synchronous active-low reset
//   in_valid / in_ready  : upstream handshake (accept = in_valid && in_ready)
//   in_insn/fields/side  : incoming entry; field k at [k*FIELD_W +: FIELD_W]
//   flush                : drop every held entry and the one offered this cycle
//   out_valid / out_ready: downstream handshake (consume = out_valid && out_ready)
//   out_insn/fields/side : head entry; NOP_INSN / 0 / 0 while !out_valid
//   occupancy            : number of held entries (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_latch
  import pipe_pkg::*;
#(
  parameter int                INSN_W     = 32,
  parameter int                NUM_FIELDS = 2,
  parameter int                FIELD_W    = 32,
  parameter int                SIDE_W     = 1,
  parameter logic [INSN_W-1:0] NOP_INSN   = INSN_W'(NOP_DEFAULT),
  parameter bit                SKID       = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSN_W-1:0]             in_insn,
  input  logic [NUM_FIELDS*FIELD_W-1:0] in_fields,
  input  logic [SIDE_W-1:0]             in_side,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [INSN_W-1:0]             out_insn,
  output logic [NUM_FIELDS*FIELD_W-1:0] out_fields,
  output logic [SIDE_W-1:0]             out_side,
  output logic [1:0]                    occupancy
);

  localparam int PAYLOAD_W = payload_w(INSN_W, NUM_FIELDS, FIELD_W, SIDE_W);

  pipe_state_e r_state;
  pipe_state_e w_next_state;

  logic                          w_accept;
  logic                          w_consume;
  logic                          w_in_ready;
  logic                          w_main_load;
  logic                          w_main_from_skid;
  logic                          w_main_clear;
  logic                          w_skid_load;
  logic                          w_skid_clear;
  logic                          w_main_valid;
  logic                          w_skid_valid;
  logic [PAYLOAD_W-1:0]          w_in_payload;
  logic [PAYLOAD_W-1:0]          w_main_d;
  logic [PAYLOAD_W-1:0]          w_main_q;
  logic [PAYLOAD_W-1:0]          w_skid_q;
  logic [INSN_W-1:0]             w_main_insn;
  logic [NUM_FIELDS*FIELD_W-1:0] w_main_fields;
  logic [SIDE_W-1:0]             w_main_side;

  assign w_accept     = in_valid && w_in_ready;
  assign w_consume    = w_main_valid && out_ready;
  assign w_in_payload = {in_insn, in_fields, in_side};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // Next state and storage control. With SKID=0, in_ready in FULL equals
  // out_ready, so an accept in FULL always coincides with a consume and the
  // ST_SKID branch is never taken.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    w_next_state     = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_main_clear     = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;

    unique case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_next_state = ST_FULL;
          w_main_load  = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_accept && w_consume) begin
          w_main_load = 1'b1;
        end else if (w_accept) begin
          w_next_state = ST_SKID;
          w_skid_load  = 1'b1;
        end else if (w_consume) begin
          w_next_state = ST_EMPTY;
          w_main_clear = 1'b1;
        end
      end
      ST_SKID: begin
        if (w_consume) begin
          w_next_state     = ST_FULL;
          w_main_load      = 1'b1;
          w_main_from_skid = 1'b1;
          w_skid_clear     = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_EMPTY;
        w_main_clear = 1'b1;
        w_skid_clear = 1'b1;
      end
    endcase

    // Flush kills everything, including an entry accepted this very cycle;
    // the upstream and downstream handshakes still complete.
    if (flush) begin
      w_next_state = ST_EMPTY;
      w_main_load  = 1'b0;
      w_skid_load  = 1'b0;
      w_main_clear = 1'b1;
      w_skid_clear = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  assign w_main_d = w_main_from_skid ? w_skid_q : w_in_payload;

  pipe_entry #(.W(PAYLOAD_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_d     (w_main_d),
    .o_q     (w_main_q),
    .o_valid (w_main_valid)
  );

  generate
    if (SKID) begin : g_skid
      logic r_in_ready;

      pipe_entry #(.W(PAYLOAD_W)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_d     (w_in_payload),
        .o_q     (w_skid_q),
        .o_valid (w_skid_valid)
      );

      // Registered ready: low exactly while the skid slot is occupied.
      always_ff @(posedge clk) begin
        if (!reset) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_next_state != ST_SKID);
        end
      end

      assign w_in_ready = r_in_ready;
    end else begin : g_no_skid
      assign w_skid_q     = '0;
      assign w_skid_valid = 1'b0;
      assign w_in_ready   = (r_state == ST_EMPTY) || out_ready;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Outputs, always from main and gated by its valid bit so a stale payload
  // (in particular a stale exception flag) never leaks downstream.
  // -------------------------------------------------------------------------
  assign {w_main_insn, w_main_fields, w_main_side} = w_main_q;

  assign in_ready   = w_in_ready;
  assign out_valid  = w_main_valid;
  assign out_insn   = w_main_valid ? w_main_insn   : NOP_INSN;
  assign out_fields = w_main_valid ? w_main_fields : '0;
  assign out_side   = w_main_valid ? w_main_side   : '0;
  assign occupancy  = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule

// File: tb/tb_pipe_stage_latch.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_latch
// Two instances: dut_a (defaults, SKID=1) and dut_b (SKID=0, 3 fields,
// non-zero NOP). A per-instance scoreboard pushes expected entries on accept
// and compares/pops them at the head as the stage presents/consumes them.
// ---------------------------------------------------------------------------
module tb_pipe_stage_latch;

  localparam logic [31:0] NOP_B = 32'h0000_0013;

  typedef struct {
    logic [31:0]  insn;
    logic [127:0] fields;
    logic         side;
  } exp_t;

  logic clk;
  logic reset;

  // dut_a signals
  logic        in_valid_a, in_ready_a, in_side_a, flush_a;
  logic [31:0] in_insn_a;
  logic [63:0] in_fields_a;
  logic        out_valid_a, out_ready_a, out_side_a;
  logic [31:0] out_insn_a;
  logic [63:0] out_fields_a;
  logic [1:0]  occ_a;

  // dut_b signals
  logic        in_valid_b, in_ready_b, in_side_b, flush_b;
  logic [31:0] in_insn_b;
  logic [95:0] in_fields_b;
  logic        out_valid_b, out_ready_b, out_side_b;
  logic [31:0] out_insn_b;
  logic [95:0] out_fields_b;
  logic [1:0]  occ_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   max_occ_a = 0;

  pipe_stage_latch dut_a (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid_a),
    .in_ready   (in_ready_a),
    .in_insn    (in_insn_a),
    .in_fields  (in_fields_a),
    .in_side    (in_side_a),
    .flush      (flush_a),
    .out_valid  (out_valid_a),
    .out_ready  (out_ready_a),
    .out_insn   (out_insn_a),
    .out_fields (out_fields_a),
    .out_side   (out_side_a),
    .occupancy  (occ_a)
  );

  pipe_stage_latch #(
    .NUM_FIELDS (3),
    .NOP_INSN   (NOP_B),
    .SKID       (1'b0)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid_b),
    .in_ready   (in_ready_b),
    .in_insn    (in_insn_b),
    .in_fields  (in_fields_b),
    .in_side    (in_side_b),
    .flush      (flush_b),
    .out_valid  (out_valid_b),
    .out_ready  (out_ready_b),
    .out_insn   (out_insn_b),
    .out_fields (out_fields_b),
    .out_side   (out_side_b),
    .occupancy  (occ_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitors (sample on falling edge) ----------
  always @(negedge clk) begin
    if (!reset) begin
      q_a.delete();
    end else begin
      check("a_occupancy", 128'(occ_a), 128'(q_a.size()));
      check("a_out_valid", 128'(out_valid_a), 128'(q_a.size() != 0));
      check("a_in_ready", 128'(in_ready_a), 128'(q_a.size() != 2));
      if (q_a.size() != 0) begin
        check("a_head_insn", 128'(out_insn_a), 128'(q_a[0].insn));
        check("a_head_fields", 128'(out_fields_a), q_a[0].fields);
        check("a_head_side", 128'(out_side_a), 128'(q_a[0].side));
      end else begin
        check("a_idle_insn", 128'(out_insn_a), 128'(0));
        check("a_idle_fields", 128'(out_fields_a), 128'(0));
        check("a_idle_side", 128'(out_side_a), 128'(0));
      end
      if (int'(occ_a) > max_occ_a) max_occ_a = int'(occ_a);
      if (out_valid_a && out_ready_a && q_a.size() != 0) void'(q_a.pop_front());
      if (flush_a) q_a.delete();
      else if (in_valid_a && in_ready_a)
        q_a.push_back('{insn: in_insn_a, fields: 128'(in_fields_a), side: in_side_a});
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      q_b.delete();
    end else begin
      check("b_occupancy", 128'(occ_b), 128'(q_b.size()));
      check("b_out_valid", 128'(out_valid_b), 128'(q_b.size() != 0));
      check("b_in_ready", 128'(in_ready_b), 128'((q_b.size() == 0) || out_ready_b));
      if (q_b.size() != 0) begin
        check("b_head_insn", 128'(out_insn_b), 128'(q_b[0].insn));
        check("b_head_fields", 128'(out_fields_b), q_b[0].fields);
        check("b_head_side", 128'(out_side_b), 128'(q_b[0].side));
      end else begin
        check("b_idle_insn", 128'(out_insn_b), 128'(NOP_B));
        check("b_idle_fields", 128'(out_fields_b), 128'(0));
      end
      if (out_valid_b && out_ready_b && q_b.size() != 0) void'(q_b.pop_front());
      if (flush_b) q_b.delete();
      else if (in_valid_b && in_ready_b)
        q_b.push_back('{insn: in_insn_b, fields: 128'(in_fields_b), side: in_side_b});
    end
  end

  // ---------------- upstream drivers (hold until accepted) ----------------
  task automatic send_a(input logic [31:0] insn, input logic side);
    logic got;
    int   n;
    in_valid_a  = 1'b1;
    in_insn_a   = insn;
    in_fields_a = {insn ^ 32'hA5A5_A5A5, ~insn};
    in_side_a   = side;
    got = 1'b0;
    n   = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = in_ready_a;
      @(posedge clk);
      #1;
      n++;
    end
    check("a_send_accepted", 128'(got), 128'(1));
  endtask

  task automatic send_b(input logic [31:0] insn, input logic [95:0] fields);
    logic got;
    int   n;
    in_valid_b  = 1'b1;
    in_insn_b   = insn;
    in_fields_b = fields;
    in_side_b   = 1'b0;
    got = 1'b0;
    n   = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = in_ready_b;
      @(posedge clk);
      #1;
      n++;
    end
    check("b_send_accepted", 128'(got), 128'(1));
  endtask

  // ---------------- stimulus ----------------------------------------------
  initial begin
    int t0;
    reset       = 1'b0;
    in_valid_a  = 1'b1;
    in_insn_a   = 32'hDEAD_BEEF;
    in_fields_a = 64'h1111_2222_3333_4444;
    in_side_a   = 1'b0;
    flush_a     = 1'b0;
    out_ready_a = 1'b0;
    in_valid_b  = 1'b0;
    in_insn_b   = '0;
    in_fields_b = '0;
    in_side_b   = 1'b0;
    flush_b     = 1'b0;
    out_ready_b = 1'b0;

    // Reset held two cycles while an entry is being offered.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid_a), 128'(0));
    check("rst_out_insn", 128'(out_insn_a), 128'(0));
    check("rst_occupancy", 128'(occ_a), 128'(0));
    check("rst_in_ready", 128'(in_ready_a), 128'(1));
    check("rst_b_out_insn", 128'(out_insn_b), 128'(NOP_B));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("first_insn", 128'(out_insn_a), 128'(32'hDEAD_BEEF));
    check("first_valid", 128'(out_valid_a), 128'(1));
    in_valid_a  = 1'b0;
    out_ready_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Stream 1..8 at full rate.
    max_occ_a = 0;
    t0 = int'($time);
    for (int i = 1; i <= 8; i++) send_a(32'(i), 1'b0);
    check("stream_cycles", 128'((int'($time) - t0) / 10), 128'(8));
    in_valid_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stream_max_occ", 128'(max_occ_a), 128'(1));
    check("stream_drained", 128'(out_valid_a), 128'(0));

    // Skid fill: downstream stalls, insn 3 must wait upstream.
    out_ready_a = 1'b0;
    fork
      begin
        send_a(32'd1, 1'b0);
        send_a(32'd2, 1'b0);
        send_a(32'd3, 1'b0);
        in_valid_a = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        check("skid_occupancy", 128'(occ_a), 128'(2));
        check("skid_in_ready", 128'(in_ready_a), 128'(0));
        check("skid_head", 128'(out_insn_a), 128'(1));
        out_ready_a = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("skid_drained_occ", 128'(occ_a), 128'(0));

    // Flush at occupancy 2 with insn 7 offered.
    out_ready_a = 1'b0;
    send_a(32'd5, 1'b0);
    send_a(32'd6, 1'b0);
    check("pre_flush_occ", 128'(occ_a), 128'(2));
    in_valid_a = 1'b1;
    in_insn_a  = 32'd7;
    flush_a    = 1'b1;
    @(posedge clk);
    #1;
    flush_a    = 1'b0;
    in_valid_a = 1'b0;
    check("flush_out_valid", 128'(out_valid_a), 128'(0));
    check("flush_out_insn", 128'(out_insn_a), 128'(0));
    check("flush_occupancy", 128'(occ_a), 128'(0));
    out_ready_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("flush_no_insn7", 128'(out_valid_a), 128'(0));

    // Flush in FULL with a simultaneous accept (dropped) and consume.
    out_ready_a = 1'b0;
    send_a(32'd9, 1'b0);
    in_valid_a  = 1'b1;
    in_insn_a   = 32'd10;
    flush_a     = 1'b1;
    out_ready_a = 1'b1;
    @(posedge clk);
    #1;
    flush_a    = 1'b0;
    in_valid_a = 1'b0;
    check("flush_acc_valid", 128'(out_valid_a), 128'(0));
    check("flush_acc_ready", 128'(in_ready_a), 128'(1));
    @(posedge clk);
    #1;
    check("flush_acc_dropped", 128'(out_valid_a), 128'(0));

    // Exception sideband must not outlive its entry.
    out_ready_a = 1'b0;
    send_a(32'h55, 1'b1);
    in_valid_a = 1'b0;
    check("side_held", 128'(out_side_a), 128'(1));
    out_ready_a = 1'b1;
    @(posedge clk);
    #1;
    check("side_cleared", 128'(out_side_a), 128'(0));
    check("side_invalid", 128'(out_valid_a), 128'(0));

    // SKID=0, three fields, out_ready toggling 1,0,1.
    out_ready_b = 1'b1;
    send_b(32'h100, {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001});
    in_valid_b = 1'b0;
    check("b_field0", 128'(out_fields_b[0 +: 32]), 128'(32'hAAAA_0001));
    check("b_field1", 128'(out_fields_b[32 +: 32]), 128'(32'hBBBB_0002));
    check("b_field2", 128'(out_fields_b[64 +: 32]), 128'(32'hCCCC_0003));
    out_ready_b = 1'b0;
    #1;
    check("b_ready_low", 128'(in_ready_b), 128'(0));
    in_valid_b  = 1'b1;
    in_insn_b   = 32'h101;
    in_fields_b = {32'hFFFF_0006, 32'hEEEE_0005, 32'hDDDD_0004};
    @(posedge clk);
    #1;
    check("b_stall_insn", 128'(out_insn_b), 128'(32'h100));
    check("b_stall_field0", 128'(out_fields_b[0 +: 32]), 128'(32'hAAAA_0001));
    out_ready_b = 1'b1;
    #1;
    check("b_ready_high", 128'(in_ready_b), 128'(1));
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    check("b_next_insn", 128'(out_insn_b), 128'(32'h101));
    check("b_next_field2", 128'(out_fields_b[64 +: 32]), 128'(32'hFFFF_0006));
    @(posedge clk);
    #1;
    check("b_empty_insn", 128'(out_insn_b), 128'(NOP_B));
    check("b_empty_fields", out_fields_b, 96'(0));

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
